multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Sequenced successor to the combinational control unit. Steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and stretches MUL/DIV over a parametrised number of cycles.
//  Stalls on a memory ready handshake. Latches exception causes, including reg-file and
//  illegal-opcode, into a sticky cause register.
//  Sits between the instruction register and the datapath, replacing the single-cycle decoder.
// PARAMETERS
//  OP_CODE_WIDTH        4  opcode field width
//  FUNCTION_CODE_WIDTH  4  function field width
//  ALU_CONTROL_WIDTH    4  alu_control width (func code passes straight through)
//  BRANCH_CONTROL_WIDTH 2  branch_control width
//  MUL_CYCLES           4  EXEC cycles for MUL (>=1)
//  DIV_CYCLES           8  EXEC cycles for DIV (>=1)
//  CNT_WIDTH            4  wait-counter width; must hold max(MUL_CYCLES,DIV_CYCLES)-1
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  op_code         in   OP  opcode from instruction register
//  func_code       in   FN  function code from instruction register
//  mem_ready       in   1   memory access completes this cycle (fetch and data)
//  exc_inst_memory, exc_alu, exc_data_memory, exc_reg_file  in  1 each  exception flags
//  ir_load, pc_inc  out 1   load IR / advance PC (FETCH with mem_ready)
//  mem_rd           out 1   instruction fetch or LW read request
//  mem_wrt          out 1   SW write request
//  jump             out 1   JMP taken
//  branch_control   out BR  11=BLT 10=BGT 01=BEQ 00=none
//  write_reg, write_r0 out 1 reg-file write enables
//  alu_control      out ALU ALU operation
//  alu_a_src, alu_b_src, reg_wr_src  out 1  datapath mux selects
//  halt             out 1   core halted (sticky until reset)
//  busy             out 1   instruction in flight (state not IDLE/HALTED)
//  exc_cause        out 5   sticky {illegal_op, reg_file, data_mem, alu, inst_mem}
// BEHAVIOUR
//  Reset (rst_n=0, any time, mid-instruction included): state=IDLE, op/func latches=0,
//   wait counter=0, exc_cause=0. All outputs are 0.
//  Opcodes: ALU=0000 LW=1000 SW=1011 BLT=0100 BGT=0101 BEQ=0110 JMP=1100 HALT=1111.
//   Funcs: ADD=1111 SUB=1110 AND=1101 OR=1100 MUL=0001 DIV=0010 SLL=1010 SLR=1011
//   ROL=1001 ROR=1000.
//  IDLE: all outputs 0. Next state is FETCH.
//  FETCH: mem_rd=1. Stays in FETCH while mem_ready=0. When mem_ready=1: ir_load=1,
//   pc_inc=1, next state is DECODE.
//  DECODE: capture op_code/func_code. Illegal opcode -> HALTED with exc_cause[4] set.
//   HALT -> HALTED. Any other opcode -> EXEC.
//  EXEC: outputs are driven from the latched op, with the same encodings as the
//   single-cycle unit.
//   - ALU: alu_control=func. alu_b_src=1 for shifts/rotates.
//     MUL/DIV: the counter loads MUL_CYCLES-1 / DIV_CYCLES-1. Stay in EXEC until the
//     counter reaches 0, decrementing by 1 per cycle. alu_control is held throughout.
//     Then go to WB.
//   - LW/SW: alu_a_src=1, alu_control=ADD, next state MEM.
//   - Branches: branch_control is asserted for exactly 1 cycle. JMP: jump=1 for
//     1 cycle. Next state FETCH.
//  MEM: LW drives mem_rd=1, SW drives mem_wrt=1, both with alu_a_src=1 and
//   alu_control=ADD. Stays in MEM while mem_ready=0.
//   On mem_ready: LW -> WB, SW -> FETCH.
//  WB: write_reg=1 for 1 cycle. write_r0=1 for MUL/DIV. reg_wr_src=1 for LW.
//   alu_control stays equal to func. Next state FETCH.
//  Latency with mem_ready=1: R-type 4 cycles, MUL 3+MUL_CYCLES, DIV 3+DIV_CYCLES,
//   LW 5, SW 4, branch/JMP 3.
//  Exceptions are sampled in every state except IDLE and HALTED. On any asserted flag:
//   - that cycle: write_reg, write_r0, mem_wrt, pc_inc, ir_load, jump, branch_control
//     are forced to 0;
//   - exc_cause ORs in every asserted flag together (simultaneous flags all captured);
//   - next state is HALTED.
//  HALTED: halt=1, busy=0, all other outputs 0. Exit only via reset. Flags arriving in
//   HALTED are ignored; exc_cause is frozen.
// STRUCTURE
//  Package control_pkg holds the opcode/func constants, the state encoding
//  (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED) and the exc_cause bit indices.
//  One sub-module, ctrl_decode: combinational op/func -> {class, ALU/mux selects,
//  multicycle count, illegal}. The top holds the FSM, latches, counter and exception gating.
// TESTING
//  1 ADD, mem_ready=1 -> FETCH,DECODE,EXEC,WB. write_reg=1 only in cycle 4,
//    alu_control=1111, write_r0=0.
//  2 MUL (func 0001), MUL_CYCLES=4 -> EXEC lasts 4 cycles. WB has write_reg=1 and
//    write_r0=1. Total 7 cycles.
//  3 LW with mem_ready held 0 for 3 cycles in MEM -> MEM persists 4 cycles.
//    WB has reg_wr_src=1. mem_wrt never 1.
//  4 SW with exc_data_memory=1 in MEM -> mem_wrt=0 that cycle, then halt=1,
//    exc_cause=00100, stays HALTED for 20 cycles.
//  5 Opcode 0011 -> HALTED after DECODE with exc_cause=10000. Also: exc_alu and
//    exc_reg_file asserted in the same cycle -> exc_cause=01010.
//  6 rst_n pulsed low mid-DIV EXEC -> all outputs 0 and exc_cause=0 immediately.
//    IDLE then FETCH after release.

Source files
------------

// File: rtl/control_pkg.sv
// Shared constants and types for the multicycle control unit: instruction
// encodings, FSM state encoding, instruction classes and exception cause bits.
package control_pkg;

    localparam int OP_W  = 4;
    localparam int FN_W  = 4;
    localparam int EXC_W = 5;

    localparam logic [OP_W-1:0] OP_ALU  = 4'b0000;
    localparam logic [OP_W-1:0] OP_LW   = 4'b1000;
    localparam logic [OP_W-1:0] OP_SW   = 4'b1011;
    localparam logic [OP_W-1:0] OP_BLT  = 4'b0100;
    localparam logic [OP_W-1:0] OP_BGT  = 4'b0101;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'b0110;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    localparam logic [FN_W-1:0] FN_ADD = 4'b1111;
    localparam logic [FN_W-1:0] FN_SUB = 4'b1110;
    localparam logic [FN_W-1:0] FN_AND = 4'b1101;
    localparam logic [FN_W-1:0] FN_OR  = 4'b1100;
    localparam logic [FN_W-1:0] FN_MUL = 4'b0001;
    localparam logic [FN_W-1:0] FN_DIV = 4'b0010;
    localparam logic [FN_W-1:0] FN_SLL = 4'b1010;
    localparam logic [FN_W-1:0] FN_SLR = 4'b1011;
    localparam logic [FN_W-1:0] FN_ROL = 4'b1001;
    localparam logic [FN_W-1:0] FN_ROR = 4'b1000;

    localparam int EXC_INST_MEM   = 0;
    localparam int EXC_ALU        = 1;
    localparam int EXC_DATA_MEM   = 2;
    localparam int EXC_REG_FILE   = 3;
    localparam int EXC_ILLEGAL_OP = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // Shifts and rotates take their second operand from the immediate path.
    function automatic logic is_shift(input logic [FN_W-1:0] fn);
        return (fn == FN_SLL) || (fn == FN_SLR) || (fn == FN_ROL) || (fn == FN_ROR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction classifier: turns an opcode/function pair
// into an instruction class, branch encoding, mux hints and the number of
// extra EXEC cycles a multicycle ALU operation needs.
module ctrl_decode
    import control_pkg::*;
#(
    parameter int OP_CODE_WIDTH        = 4,
    parameter int FUNCTION_CODE_WIDTH  = 4,
    parameter int BRANCH_CONTROL_WIDTH = 2,
    parameter int MUL_CYCLES           = 4,
    parameter int DIV_CYCLES           = 8,
    parameter int CNT_WIDTH            = 4
) (
    input  logic [OP_CODE_WIDTH-1:0]        op_code,
    input  logic [FUNCTION_CODE_WIDTH-1:0]  func_code,
    output op_class_t                       op_class,
    output logic [BRANCH_CONTROL_WIDTH-1:0] branch_code,
    output logic                            shift_op,
    output logic                            mul_div,
    output logic [CNT_WIDTH-1:0]            wait_count,
    output logic                            illegal
);

    // Classify the instruction; unknown opcodes are flagged illegal.
    always_comb begin
        op_class    = CLS_ILLEGAL;
        branch_code = '0;
        shift_op    = 1'b0;
        mul_div     = 1'b0;
        wait_count  = '0;
        illegal     = 1'b0;
        case (op_code)
            OP_ALU: begin
                op_class = CLS_ALU;
                shift_op = is_shift(func_code);
                if (func_code == FN_MUL) begin
                    mul_div    = 1'b1;
                    wait_count = CNT_WIDTH'(MUL_CYCLES - 1);
                end else if (func_code == FN_DIV) begin
                    mul_div    = 1'b1;
                    wait_count = CNT_WIDTH'(DIV_CYCLES - 1);
                end
            end
            OP_LW:   op_class = CLS_LOAD;
            OP_SW:   op_class = CLS_STORE;
            OP_BLT: begin
                op_class    = CLS_BRANCH;
                branch_code = BRANCH_CONTROL_WIDTH'(2'b11);
            end
            OP_BGT: begin
                op_class    = CLS_BRANCH;
                branch_code = BRANCH_CONTROL_WIDTH'(2'b10);
            end
            OP_BEQ: begin
                op_class    = CLS_BRANCH;
                branch_code = BRANCH_CONTROL_WIDTH'(2'b01);
            end
            OP_JMP:  op_class = CLS_JUMP;
            OP_HALT: op_class = CLS_HALT;
            default: begin
                op_class = CLS_ILLEGAL;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, stretches MUL/DIV in EXEC, stalls on mem_ready and
// halts on any exception, keeping a sticky record of the causes.
module multicycle_control
    import control_pkg::*;
#(
    parameter int OP_CODE_WIDTH        = 4,
    parameter int FUNCTION_CODE_WIDTH  = 4,
    parameter int ALU_CONTROL_WIDTH    = 4,
    parameter int BRANCH_CONTROL_WIDTH = 2,
    parameter int MUL_CYCLES           = 4,
    parameter int DIV_CYCLES           = 8,
    parameter int CNT_WIDTH            = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [OP_CODE_WIDTH-1:0]        op_code,
    input  logic [FUNCTION_CODE_WIDTH-1:0]  func_code,
    input  logic                            mem_ready,
    input  logic                            exc_inst_memory,
    input  logic                            exc_alu,
    input  logic                            exc_data_memory,
    input  logic                            exc_reg_file,
    output logic                            ir_load,
    output logic                            pc_inc,
    output logic                            mem_rd,
    output logic                            mem_wrt,
    output logic                            jump,
    output logic [BRANCH_CONTROL_WIDTH-1:0] branch_control,
    output logic                            write_reg,
    output logic                            write_r0,
    output logic [ALU_CONTROL_WIDTH-1:0]    alu_control,
    output logic                            alu_a_src,
    output logic                            alu_b_src,
    output logic                            reg_wr_src,
    output logic                            halt,
    output logic                            busy,
    output logic [EXC_W-1:0]                exc_cause
);

    state_t state, next_state;

    logic [OP_CODE_WIDTH-1:0]        op_q;
    logic [FUNCTION_CODE_WIDTH-1:0]  func_q;
    logic [CNT_WIDTH-1:0]            cnt;

    logic [OP_CODE_WIDTH-1:0]        dec_op;
    logic [FUNCTION_CODE_WIDTH-1:0]  dec_func;
    op_class_t                       op_class;
    logic [BRANCH_CONTROL_WIDTH-1:0] branch_code;
    logic                            shift_op;
    logic                            mul_div;
    logic [CNT_WIDTH-1:0]            wait_count;
    logic                            illegal;

    logic [3:0]                      exc_flags;
    logic                            exc_active;
    logic                            exc_hit;
    logic [EXC_W-1:0]                new_cause;

    // DECODE classifies the live IR fields; later states use the captured copy.
    assign dec_op   = (state == DECODE) ? op_code   : op_q;
    assign dec_func = (state == DECODE) ? func_code : func_q;

    assign exc_flags  = {exc_reg_file, exc_data_memory, exc_alu, exc_inst_memory};
    assign exc_active = (state != IDLE) && (state != HALTED);
    assign exc_hit    = exc_active && (|exc_flags);

    assign new_cause = (exc_hit ? {1'b0, exc_flags} : '0)
                     | (((state == DECODE) && illegal) ? EXC_W'(1) << EXC_ILLEGAL_OP : '0);

    ctrl_decode #(
        .OP_CODE_WIDTH        (OP_CODE_WIDTH),
        .FUNCTION_CODE_WIDTH  (FUNCTION_CODE_WIDTH),
        .BRANCH_CONTROL_WIDTH (BRANCH_CONTROL_WIDTH),
        .MUL_CYCLES           (MUL_CYCLES),
        .DIV_CYCLES           (DIV_CYCLES),
        .CNT_WIDTH            (CNT_WIDTH)
    ) u_decode (
        .op_code     (dec_op),
        .func_code   (dec_func),
        .op_class    (op_class),
        .branch_code (branch_code),
        .shift_op    (shift_op),
        .mul_div     (mul_div),
        .wait_count  (wait_count),
        .illegal     (illegal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Instruction latches, multicycle wait counter and sticky exception causes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            func_q    <= '0;
            cnt       <= '0;
            exc_cause <= '0;
        end else begin
            if (state == DECODE) begin
                op_q   <= op_code;
                func_q <= func_code;
                cnt    <= wait_count;
            end else if ((state == EXEC) && (cnt != '0)) begin
                cnt <= cnt - CNT_WIDTH'(1);
            end
            exc_cause <= exc_cause | new_cause;
        end
    end

    // Next-state logic; any exception overrides the normal sequence.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   next_state = FETCH;
            FETCH:  next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (illegal || (op_class == CLS_HALT)) begin
                    next_state = HALTED;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                case (op_class)
                    CLS_ALU:               next_state = (cnt == '0) ? WB : EXEC;
                    CLS_LOAD, CLS_STORE:   next_state = MEM;
                    default:               next_state = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    next_state = (op_class == CLS_LOAD) ? WB : FETCH;
                end
            end
            WB:     next_state = FETCH;
            HALTED: next_state = HALTED;
            default: next_state = IDLE;
        endcase
        if (exc_hit) begin
            next_state = HALTED;
        end
    end

    // Per-state control outputs, with side-effecting strobes suppressed on an exception.
    always_comb begin
        ir_load        = 1'b0;
        pc_inc         = 1'b0;
        mem_rd         = 1'b0;
        mem_wrt        = 1'b0;
        jump           = 1'b0;
        branch_control = '0;
        write_reg      = 1'b0;
        write_r0       = 1'b0;
        alu_control    = '0;
        alu_a_src      = 1'b0;
        alu_b_src      = 1'b0;
        reg_wr_src     = 1'b0;
        halt           = 1'b0;
        busy           = exc_active;
        unique case (state)
            FETCH: begin
                mem_rd  = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            EXEC: begin
                case (op_class)
                    CLS_ALU: begin
                        alu_control = ALU_CONTROL_WIDTH'(func_q);
                        alu_b_src   = shift_op;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_a_src   = 1'b1;
                        alu_control = ALU_CONTROL_WIDTH'(FN_ADD);
                    end
                    CLS_BRANCH: branch_control = branch_code;
                    CLS_JUMP:   jump = 1'b1;
                    default: ;
                endcase
            end
            MEM: begin
                alu_a_src   = 1'b1;
                alu_control = ALU_CONTROL_WIDTH'(FN_ADD);
                mem_rd      = (op_class == CLS_LOAD);
                mem_wrt     = (op_class == CLS_STORE);
            end
            WB: begin
                write_reg   = 1'b1;
                write_r0    = mul_div;
                reg_wr_src  = (op_class == CLS_LOAD);
                alu_control = ALU_CONTROL_WIDTH'(func_q);
            end
            HALTED: halt = 1'b1;
            default: ;
        endcase
        if (exc_hit) begin
            write_reg      = 1'b0;
            write_r0       = 1'b0;
            mem_wrt        = 1'b0;
            pc_inc         = 1'b0;
            ir_load        = 1'b0;
            jump           = 1'b0;
            branch_control = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: walks hand-computed
// per-cycle output vectors for each instruction class, stalls, exceptions and reset.
module tb_multicycle_control;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] op_code;
    logic [3:0] func_code;
    logic       mem_ready;
    logic       exc_inst_memory, exc_alu, exc_data_memory, exc_reg_file;
    logic       ir_load, pc_inc, mem_rd, mem_wrt, jump;
    logic [1:0] branch_control;
    logic       write_reg, write_r0;
    logic [3:0] alu_control;
    logic       alu_a_src, alu_b_src, reg_wr_src, halt, busy;
    logic [4:0] exc_cause;

    logic [31:0] obs;
    int errors = 0;
    int checks = 0;

    multicycle_control dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_code         (op_code),
        .func_code       (func_code),
        .mem_ready       (mem_ready),
        .exc_inst_memory (exc_inst_memory),
        .exc_alu         (exc_alu),
        .exc_data_memory (exc_data_memory),
        .exc_reg_file    (exc_reg_file),
        .ir_load         (ir_load),
        .pc_inc          (pc_inc),
        .mem_rd          (mem_rd),
        .mem_wrt         (mem_wrt),
        .jump            (jump),
        .branch_control  (branch_control),
        .write_reg       (write_reg),
        .write_r0        (write_r0),
        .alu_control     (alu_control),
        .alu_a_src       (alu_a_src),
        .alu_b_src       (alu_b_src),
        .reg_wr_src      (reg_wr_src),
        .halt            (halt),
        .busy            (busy),
        .exc_cause       (exc_cause)
    );

    always #5 clk = ~clk;

    assign obs = {14'b0, ir_load, pc_inc, mem_rd, mem_wrt, jump, branch_control,
                  write_reg, write_r0, alu_control, alu_a_src, alu_b_src,
                  reg_wr_src, halt, busy};

    function automatic logic [31:0] ctl(input bit ir, input bit pc, input bit rd,
                                        input bit wr, input bit jmp, input logic [1:0] br,
                                        input bit wreg, input bit wr0, input logic [3:0] alu,
                                        input bit asrc, input bit bsrc, input bit wsrc,
                                        input bit hlt, input bit bsy);
        return {14'b0, ir, pc, rd, wr, jmp, br, wreg, wr0, alu, asrc, bsrc, wsrc, hlt, bsy};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // exc is {reg_file, data_mem, alu, inst_mem}
    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] fn,
                                 input logic rdy, input logic [3:0] exc);
        @(negedge clk);
        op_code   = op;
        func_code = fn;
        mem_ready = rdy;
        {exc_reg_file, exc_data_memory, exc_alu, exc_inst_memory} = exc;
        #1;
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        op_code   = '0;
        func_code = '0;
        mem_ready = 1'b0;
        {exc_reg_file, exc_data_memory, exc_alu, exc_inst_memory} = 4'b0;
        #1;
        checkOutput({tag, "_outs"}, obs, 32'h0);
        checkOutput({tag, "_cause"}, {27'b0, exc_cause}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput({tag, "_idle"}, obs, 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        op_code = '0; func_code = '0; mem_ready = 1'b0;
        {exc_reg_file, exc_data_memory, exc_alu, exc_inst_memory} = 4'b0;
        doReset("rst0");

        // ADD: FETCH, DECODE, EXEC, WB
        applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b0);
        checkOutput("add_fetch", obs, ctl(H,H,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b0);
        checkOutput("add_decode", obs, ctl(L,L,L,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b0);
        checkOutput("add_exec", obs, ctl(L,L,L,L,L,2'b00,L,L,4'hF,L,L,L,L,H));
        applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b0);
        checkOutput("add_wb", obs, ctl(L,L,L,L,L,2'b00,H,L,4'hF,L,L,L,L,H));

        // MUL: EXEC stretched to 4 cycles, WB writes r0
        applyStimulus(4'b0000, 4'b0001, 1'b1, 4'b0);
        checkOutput("mul_fetch", obs, ctl(H,H,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0000, 4'b0001, 1'b1, 4'b0);
        checkOutput("mul_decode", obs, ctl(L,L,L,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 4'b0001, 1'b1, 4'b0);
            checkOutput($sformatf("mul_exec%0d", i), obs, ctl(L,L,L,L,L,2'b00,L,L,4'h1,L,L,L,L,H));
        end
        applyStimulus(4'b0000, 4'b0001, 1'b1, 4'b0);
        checkOutput("mul_wb", obs, ctl(L,L,L,L,L,2'b00,H,H,4'h1,L,L,L,L,H));

        // SLL: shift selects immediate B operand
        applyStimulus(4'b0000, 4'b1010, 1'b1, 4'b0);
        checkOutput("sll_fetch", obs, ctl(H,H,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0000, 4'b1010, 1'b1, 4'b0);
        applyStimulus(4'b0000, 4'b1010, 1'b1, 4'b0);
        checkOutput("sll_exec", obs, ctl(L,L,L,L,L,2'b00,L,L,4'hA,L,H,L,L,H));
        applyStimulus(4'b0000, 4'b1010, 1'b1, 4'b0);
        checkOutput("sll_wb", obs, ctl(L,L,L,L,L,2'b00,H,L,4'hA,L,L,L,L,H));

        // LW with a 3-cycle memory stall in MEM
        applyStimulus(4'b1000, 4'b1111, 1'b1, 4'b0);
        checkOutput("lw_fetch", obs, ctl(H,H,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b1000, 4'b1111, 1'b1, 4'b0);
        applyStimulus(4'b1000, 4'b1111, 1'b1, 4'b0);
        checkOutput("lw_exec", obs, ctl(L,L,L,L,L,2'b00,L,L,4'hF,H,L,L,L,H));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1000, 4'b1111, (i == 3) ? 1'b1 : 1'b0, 4'b0);
            checkOutput($sformatf("lw_mem%0d", i), obs, ctl(L,L,H,L,L,2'b00,L,L,4'hF,H,L,L,L,H));
        end
        applyStimulus(4'b1000, 4'b1111, 1'b1, 4'b0);
        checkOutput("lw_wb", obs, ctl(L,L,L,L,L,2'b00,H,L,4'hF,L,L,H,L,H));

        // Branches and jump: one EXEC cycle then back to FETCH
        applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0);
        checkOutput("blt_fetch", obs, ctl(H,H,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0);
        checkOutput("blt_exec", obs, ctl(L,L,L,L,L,2'b11,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0101, 4'b0000, 1'b1, 4'b0);
        checkOutput("bgt_fetch", obs, ctl(H,H,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0101, 4'b0000, 1'b1, 4'b0);
        applyStimulus(4'b0101, 4'b0000, 1'b1, 4'b0);
        checkOutput("bgt_exec", obs, ctl(L,L,L,L,L,2'b10,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0110, 4'b0000, 1'b1, 4'b0);
        applyStimulus(4'b0110, 4'b0000, 1'b1, 4'b0);
        applyStimulus(4'b0110, 4'b0000, 1'b1, 4'b0);
        checkOutput("beq_exec", obs, ctl(L,L,L,L,L,2'b01,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b1100, 4'b0000, 1'b1, 4'b0);
        applyStimulus(4'b1100, 4'b0000, 1'b1, 4'b0);
        applyStimulus(4'b1100, 4'b0000, 1'b1, 4'b0);
        checkOutput("jmp_exec", obs, ctl(L,L,L,L,H,2'b00,L,L,4'h0,L,L,L,L,H));

        // SW hit by a data-memory exception in MEM
        applyStimulus(4'b1011, 4'b1111, 1'b1, 4'b0);
        checkOutput("sw_fetch", obs, ctl(H,H,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b1011, 4'b1111, 1'b1, 4'b0);
        applyStimulus(4'b1011, 4'b1111, 1'b1, 4'b0);
        checkOutput("sw_exec", obs, ctl(L,L,L,L,L,2'b00,L,L,4'hF,H,L,L,L,H));
        applyStimulus(4'b1011, 4'b1111, 1'b1, 4'b0100);
        checkOutput("sw_mem_exc", obs, ctl(L,L,L,L,L,2'b00,L,L,4'hF,H,L,L,L,H));
        checkOutput("sw_mem_cause", {27'b0, exc_cause}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0000, 4'b1111, 1'b1, 4'(i));
            checkOutput($sformatf("sw_halted%0d", i), obs, ctl(L,L,L,L,L,2'b00,L,L,4'h0,L,L,L,H,L));
            checkOutput($sformatf("sw_cause%0d", i), {27'b0, exc_cause}, 32'h04);
        end

        // Illegal opcode halts after DECODE
        doReset("rst1");
        applyStimulus(4'b0011, 4'b0000, 1'b1, 4'b0);
        checkOutput("ill_fetch", obs, ctl(H,H,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0011, 4'b0000, 1'b1, 4'b0);
        checkOutput("ill_decode", obs, ctl(L,L,L,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0011, 4'b0000, 1'b1, 4'b0);
        checkOutput("ill_halted", obs, ctl(L,L,L,L,L,2'b00,L,L,4'h0,L,L,L,H,L));
        checkOutput("ill_cause", {27'b0, exc_cause}, 32'h10);

        // Simultaneous ALU and reg-file exceptions during FETCH
        doReset("rst2");
        applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b1010);
        checkOutput("dual_fetch", obs, ctl(L,L,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0000, 4'b1111, 1'b1, 4'b0);
        checkOutput("dual_halted", obs, ctl(L,L,L,L,L,2'b00,L,L,4'h0,L,L,L,H,L));
        checkOutput("dual_cause", {27'b0, exc_cause}, 32'h0A);

        // HALT opcode halts without a cause
        doReset("rst3");
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0);
        checkOutput("hlt_halted", obs, ctl(L,L,L,L,L,2'b00,L,L,4'h0,L,L,L,H,L));
        checkOutput("hlt_cause", {27'b0, exc_cause}, 32'h0);

        // Reset in the middle of a DIV
        doReset("rst4");
        applyStimulus(4'b0000, 4'b0010, 1'b1, 4'b0);
        applyStimulus(4'b0000, 4'b0010, 1'b1, 4'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 4'b0010, 1'b1, 4'b0);
            checkOutput($sformatf("div_exec%0d", i), obs, ctl(L,L,L,L,L,2'b00,L,L,4'h2,L,L,L,L,H));
        end
        doReset("div_rst");
        applyStimulus(4'b0000, 4'b0010, 1'b1, 4'b0);
        checkOutput("div_refetch", obs, ctl(H,H,H,L,L,2'b00,L,L,4'h0,L,L,L,L,H));
        applyStimulus(4'b0000, 4'b0010, 1'b1, 4'b0);
        checkOutput("div_redecode", obs, ctl(L,L,L,L,L,2'b00,L,L,4'h0,L,L,L,L,H));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
